mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width in bits; the result is 2*WIDTH bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port flush, input, 1 bit: abandons any in-flight operation.
REQ-005 SHALL have port in_valid, input, 1 bit: the operands are offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 SHALL have port in_signed, input, 1 bit: 1 treats a and b as two's complement, 0 treats them as unsigned.
REQ-008 SHALL have port a, input, WIDTH bits: the multiplicand.
REQ-009 SHALL have port b, input, WIDTH bits: the multiplier.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 SHALL have port result, output, 2*WIDTH bits: the product.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-015 SHALL drive in_ready high only in IDLE; an accept is in_valid && in_ready.
REQ-016 SHALL, on accept, latch |a| and |b|, where magnitudes are taken only when in_signed=1, and latch the sign flag neg = in_signed & (a[MSB] ^ b[MSB]).
REQ-017 SHALL, on accept, clear the 2*WIDTH-bit accumulator and the iteration counter, and go to CALC.
REQ-018 SHALL use exactly one WIDTH-bit add with carry-out per CALC cycle: if the multiplier LSB is 1, {carry, acc_hi} = acc_hi + multiplicand, otherwise {carry, acc_hi} = acc_hi + 0.
REQ-019 SHALL, each CALC cycle, shift {carry, acc_hi, acc_lo} right by one bit and shift the multiplier right by one bit.
REQ-020 SHALL remain in CALC for exactly WIDTH cycles, counted by a counter from 0 to WIDTH-1, then go to DONE.
REQ-021 SHALL, on the transition into DONE, register result as the accumulator, two's-complement negated when neg=1.
REQ-022 SHALL set latency so that an accept at cycle T gives CALC over T+1..T+WIDTH and out_valid=1 from T+WIDTH+1.
REQ-023 SHALL keep out_valid high and result stable in DONE until out_valid && out_ready, then return to IDLE on the next edge.
REQ-024 SHALL not accept new operands in the cycle a result is consumed; in_ready is asserted from the following cycle.
REQ-025 SHALL, when flush=1 in any state, go to IDLE on the next edge with out_valid=0, discarding the in-flight operation and any unconsumed result.
REQ-026 SHALL give flush priority over accept in the same cycle, so no operation starts.
REQ-027 SHALL return the exact 2*WIDTH-bit product for every operand pair, including zero operands.
REQ-028 SHALL return 2^(2*WIDTH-2) for the signed case a = b = -2^(WIDTH-1).
REQ-029 SHALL hold result unchanged outside DONE; it changes only on DONE entry or reset.
REQ-030 SHALL ignore in_valid, a, b and in_signed outside IDLE.

Reset
REQ-031 SHALL, when rst=1, on the next edge set: state IDLE, counter 0, accumulator 0, result 0, neg 0.
REQ-032 SHALL drive out_valid=0, busy=0 and in_ready=1 from the first edge after rst=1.
REQ-033 SHALL give rst priority over flush and over any handshake, including a reset asserted mid-CALC or in DONE.

Verification
REQ-034 SHALL cover an unsigned full-scale multiply (WIDTH=32): in_signed=0, a=b=0xFFFFFFFF accepted at T -> out_valid at T+33, result=0xFFFFFFFE00000001.
REQ-035 SHALL cover signed operands: in_signed=1, a=0xFFFFFFFD (-3), b=5 -> result=0xFFFFFFFFFFFFFFF1; a=b=0x80000000 -> result=0x4000000000000000.
REQ-036 SHALL cover back-pressure: out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0; out_ready=1 -> in_ready=1 one cycle after the consume.
REQ-037 SHALL cover flush mid-operation: flush at T+10 -> IDLE at T+11, out_valid never asserted; the next operation 7*6 -> 42.
REQ-038 SHALL cover reset mid-CALC and in DONE: rst=1 -> next cycle out_valid=0, busy=0, result=0, in_ready=1.
REQ-039 SHALL cover back-to-back operations: 0*0x12345678 -> 0, then 1*0xFFFFFFFF (unsigned) -> 0x00000000FFFFFFFF, with no lost or duplicated handshakes.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier.
// Signed operands are converted to magnitudes on accept; the product sign is
// applied once, when the result is registered on entry to DONE. Each CALC
// cycle performs one WIDTH-bit add into the upper accumulator half and then
// shifts {carry, acc} right, so that after WIDTH cycles acc holds the product.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;

  // Status outputs decode directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Operand magnitudes and the single add-and-shift step of the datapath.
  always_comb begin
    mag_a    = (in_signed && a[WIDTH-1]) ? -a : a;
    mag_b    = (in_signed && b[WIDTH-1]) ? -b : b;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    // {carry, acc_hi + addend, acc_lo} shifted right by one; bit 0 falls off.
    acc_next = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
  end

  // Control FSM and datapath registers; rst beats flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            result <= neg ? -acc_next : acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
